// File: rtl/sr_latch_driver.sv
// Drives legal s/r pulses into an external SR element and confirms the result via q/qbar.
// Optional build macro SR_LATCH_DRV_SKIP_EN skips the pulse when the element already holds the value.
module sr_latch_driver #(
  parameter int PULSE_CYCLES = 2,
  parameter int SETTLE_MAX   = 8,
  parameter int CNT_W        = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic       req_bit,
  output logic       req_ready,
  output logic       s,
  output logic       r,
  input  logic       q_fb,
  input  logic       qbar_fb,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  output logic       stored
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    PULSE  = 3'd2,
    SETTLE = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] PULSE_LD  = CNT_W'(PULSE_CYCLES);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_MAX);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tgt_q, tgt_d;
  logic             q_s1_q, q_s2_q;
  logic             qb_s1_q, qb_s2_q;

  logic             s_q, s_d;
  logic             r_q, r_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;
  logic             stored_q, stored_d;
  logic             ready_q, ready_d;

  logic qs, qbs, match, illegal;

  assign qs      = q_s2_q;
  assign qbs     = qb_s2_q;
  assign match   = (qs == tgt_q) && (qbs == ~tgt_q);
  assign illegal = (qs == qbs);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      tgt_q      <= 1'b0;
      q_s1_q     <= 1'b0;
      q_s2_q     <= 1'b0;
      qb_s1_q    <= 1'b0;
      qb_s2_q    <= 1'b0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
      stored_q   <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tgt_q      <= tgt_d;
      q_s1_q     <= q_fb;
      q_s2_q     <= q_s1_q;
      qb_s1_q    <= qbar_fb;
      qb_s2_q    <= qb_s1_q;
      s_q        <= s_d;
      r_q        <= r_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      stored_q   <= stored_d;
      ready_q    <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          tgt_d   = req_bit;
          state_d = CHECK;
        end
      end
      CHECK: begin
`ifdef SR_LATCH_DRV_SKIP_EN
        if (match) begin
          state_d = DONE;
        end else begin
          cnt_d   = PULSE_LD;
          state_d = PULSE;
        end
`else
        cnt_d   = PULSE_LD;
        state_d = PULSE;
`endif
      end
      PULSE: begin
        if (cnt_q <= ONE) begin
          cnt_d   = SETTLE_LD;
          state_d = SETTLE;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      SETTLE: begin
        if (match) begin
          cnt_d   = '0;
          state_d = DONE;
        end else if (cnt_q <= ONE) begin
          cnt_d   = '0;
          state_d = ERR;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every port comes straight off a flop.
  always_comb begin
    s_d        = (state_d == PULSE) && tgt_d;
    r_d        = (state_d == PULSE) && !tgt_d;
    busy_d     = (state_d != IDLE);
    ready_d    = (state_d == IDLE);
    done_d     = (state_d == DONE);
    err_d      = (state_d == ERR);
    err_code_d = err_code_q;
    stored_d   = stored_q;
    if (state_d == ERR) err_code_d = illegal ? 2'b10 : 2'b01;
    if (state_d == DONE) stored_d = tgt_d;
  end

  assign s         = s_q;
  assign r         = r_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign stored    = stored_q;
  assign req_ready = ready_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed bench for sr_latch_driver with a behavioural SR element model.
// Cycle 0 is the handshake cycle; cycle n is the interval after the n-th rising edge.
module tb_sr_latch_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_bit = 1'b0;
  logic       req_ready;
  logic       s, r;
  logic       q_fb = 1'b0;
  logic       qbar_fb = 1'b1;
  logic       busy, done, err;
  logic [1:0] err_code;
  logic       stored;

  int total = 0;
  int bad = 0;
  int viol = 0;
  int mode = 0;
  logic pend_s = 1'b0;
  logic pend_r = 1'b0;

  int s_first, s_cnt, r_cnt, done_at, done_cnt, err_at;
  logic [1:0] code_at;
  logic rdy_a [0:16];
  logic bsy_a [0:16];
  logic sto_a [0:16];

  sr_latch_driver dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_bit   (req_bit),
    .req_ready (req_ready),
    .s         (s),
    .r         (r),
    .q_fb      (q_fb),
    .qbar_fb   (qbar_fb),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_code  (err_code),
    .stored    (stored)
  );

  always #5 clk = ~clk;

  // Element model: mode 0 follows s/r two cycles late, 1 stuck at 0, 2 q=qbar=1.
  always @(posedge clk) begin
    pend_s <= s;
    pend_r <= r;
    if (mode == 1) begin
      q_fb <= 1'b0; qbar_fb <= 1'b1;
    end else if (mode == 2) begin
      q_fb <= 1'b1; qbar_fb <= 1'b1;
    end else if (pend_s) begin
      q_fb <= 1'b1; qbar_fb <= 1'b0;
    end else if (pend_r) begin
      q_fb <= 1'b0; qbar_fb <= 1'b1;
    end
  end

  always @(negedge clk) if (s && r) viol++;

  task automatic run_write(input logic b);
    s_first = -1; s_cnt = 0; r_cnt = 0;
    done_at = -1; done_cnt = 0; err_at = -1; code_at = 2'b00;
    @(negedge clk);
    rdy_a[0] = req_ready; bsy_a[0] = busy; sto_a[0] = stored;
    req_valid = 1'b1; req_bit = b;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 1) req_valid = 1'b0;
      rdy_a[i] = req_ready; bsy_a[i] = busy; sto_a[i] = stored;
      if (s) begin s_cnt++; if (s_first < 0) s_first = i; end
      if (r) r_cnt++;
      if (done) begin done_cnt++; if (done_at < 0) done_at = i; end
      if (err && err_at < 0) begin err_at = i; code_at = err_code; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (s !== 1'b0 || r !== 1'b0) begin bad++; $display("FAIL reset_sr got=%b%b want=00", s, r); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL reset_done_err got=%b%b want=00", done, err); end
    total++; if (err_code !== 2'b00) begin bad++; $display("FAIL reset_code got=%b want=00", err_code); end
    total++; if (stored !== 1'b0) begin bad++; $display("FAIL reset_stored got=%b want=0", stored); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", req_ready); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write_one;
    run_write(1'b1);
    total++; if (rdy_a[0] !== 1'b1) begin bad++; $display("FAIL w1_ready0 got=%b want=1", rdy_a[0]); end
    total++; if (s_first != 2) begin bad++; $display("FAIL w1_s_first got=%0d want=2", s_first); end
    total++; if (s_cnt != 2) begin bad++; $display("FAIL w1_s_cnt got=%0d want=2", s_cnt); end
    total++; if (r_cnt != 0) begin bad++; $display("FAIL w1_r_cnt got=%0d want=0", r_cnt); end
    total++; if (done_at != 7) begin bad++; $display("FAIL w1_done_at got=%0d want=7", done_at); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL w1_done_cnt got=%0d want=1", done_cnt); end
    total++; if (err_at != -1) begin bad++; $display("FAIL w1_err got=%0d want=-1", err_at); end
    total++; if (rdy_a[1] !== 1'b0 || bsy_a[1] !== 1'b1) begin bad++; $display("FAIL w1_busy1 got=%b%b want=01", rdy_a[1], bsy_a[1]); end
    total++; if (sto_a[6] !== 1'b0 || sto_a[7] !== 1'b1) begin bad++; $display("FAIL w1_stored got=%b%b want=01", sto_a[6], sto_a[7]); end
    total++; if (rdy_a[7] !== 1'b0) begin bad++; $display("FAIL w1_ready_done got=%b want=0", rdy_a[7]); end
    total++; if (rdy_a[8] !== 1'b1 || bsy_a[8] !== 1'b0) begin bad++; $display("FAIL w1_idle8 got=%b%b want=10", rdy_a[8], bsy_a[8]); end
  endtask

  task automatic test_write_zero;
    run_write(1'b0);
    total++; if (r_cnt != 2) begin bad++; $display("FAIL w0_r_cnt got=%0d want=2", r_cnt); end
    total++; if (s_cnt != 0) begin bad++; $display("FAIL w0_s_cnt got=%0d want=0", s_cnt); end
    total++; if (done_at != 7) begin bad++; $display("FAIL w0_done_at got=%0d want=7", done_at); end
    total++; if (sto_a[16] !== 1'b0) begin bad++; $display("FAIL w0_stored got=%b want=0", sto_a[16]); end
    total++; if (viol != 0) begin bad++; $display("FAIL w0_sr_overlap got=%0d want=0", viol); end
  endtask

  task automatic test_back_to_back;
    run_write(1'b1);
    total++; if (done_at != 7) begin bad++; $display("FAIL b2b_first_done got=%0d want=7", done_at); end
    run_write(1'b1);
`ifdef SR_LATCH_DRV_SKIP_EN
    total++; if (s_cnt != 0) begin bad++; $display("FAIL b2b_s_cnt got=%0d want=0", s_cnt); end
    total++; if (done_at != 2) begin bad++; $display("FAIL b2b_done_at got=%0d want=2", done_at); end
`else
    total++; if (s_cnt != 2) begin bad++; $display("FAIL b2b_s_cnt got=%0d want=2", s_cnt); end
    total++; if (done_at != 5) begin bad++; $display("FAIL b2b_done_at got=%0d want=5", done_at); end
`endif
    total++; if (sto_a[16] !== 1'b1) begin bad++; $display("FAIL b2b_stored got=%b want=1", sto_a[16]); end
  endtask

  task automatic test_timeout;
    mode = 1;
    repeat (4) @(negedge clk);
    run_write(1'b1);
    total++; if (s_cnt != 2) begin bad++; $display("FAIL to_s_cnt got=%0d want=2", s_cnt); end
    total++; if (err_at != 12) begin bad++; $display("FAIL to_err_at got=%0d want=12", err_at); end
    total++; if (code_at !== 2'b01) begin bad++; $display("FAIL to_code got=%b want=01", code_at); end
    total++; if (done_cnt != 0) begin bad++; $display("FAIL to_done got=%0d want=0", done_cnt); end
    total++; if (sto_a[12] !== 1'b1) begin bad++; $display("FAIL to_stored got=%b want=1", sto_a[12]); end
    total++; if (rdy_a[11] !== 1'b0 || rdy_a[13] !== 1'b1) begin bad++; $display("FAIL to_ready got=%b%b want=01", rdy_a[11], rdy_a[13]); end
    total++; if (err_code !== 2'b01) begin bad++; $display("FAIL to_code_hold got=%b want=01", err_code); end
  endtask

  task automatic test_illegal;
    mode = 2;
    repeat (4) @(negedge clk);
    run_write(1'b0);
    total++; if (r_cnt != 2) begin bad++; $display("FAIL il_r_cnt got=%0d want=2", r_cnt); end
    total++; if (err_at != 12) begin bad++; $display("FAIL il_err_at got=%0d want=12", err_at); end
    total++; if (code_at !== 2'b10) begin bad++; $display("FAIL il_code got=%b want=10", code_at); end
    total++; if (sto_a[16] !== 1'b1) begin bad++; $display("FAIL il_stored got=%b want=1", sto_a[16]); end
    total++; if (viol != 0) begin bad++; $display("FAIL il_sr_overlap got=%0d want=0", viol); end
  endtask

  task automatic test_reset_mid;
    int de;
    mode = 0;
    de = 0;
    @(negedge clk);
    req_valid = 1'b1; req_bit = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    total++; if (r !== 1'b1) begin bad++; $display("FAIL rm_pulse got=%b want=1", r); end
    rst_n = 1'b0;
    #1;
    total++; if (s !== 1'b0 || r !== 1'b0) begin bad++; $display("FAIL rm_sr_drop got=%b%b want=00", s, r); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rm_busy got=%b want=0", busy); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done || err) de++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done || err) de++;
    end
    total++; if (de != 0) begin bad++; $display("FAIL rm_done_err got=%0d want=0", de); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rm_ready got=%b want=1", req_ready); end
    total++; if (stored !== 1'b0) begin bad++; $display("FAIL rm_stored got=%b want=0", stored); end
  endtask

  initial begin
    test_reset;
    test_write_one;
    test_write_zero;
    test_back_to_back;
    test_timeout;
    test_illegal;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sr_latch_driver.md
Name: sr_latch_driver

Overview:
Synchronous initiator that writes a requested value into an external set/reset storage element by driving its s/r excitation inputs.
It monitors the element's q/qbar feedback and reports completion or failure.
It sits between clocked control logic and the gate-level SR flip-flop cells, producing legal S/R pulses only; s=r=1 is never driven.
It accepts one write request at a time over a valid/ready handshake.

Parameters:
PULSE_CYCLES, 2, number of clk cycles s or r is held high per write (legal range 1..15)
SETTLE_MAX, 8, max cycles after pulse end to wait for feedback to match (legal range 1..15)
CNT_W, 4, width of internal pulse/settle counter; must satisfy 2^CNT_W-1 >= max(PULSE_CYCLES, SETTLE_MAX)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous assert, active-low
req_valid  input  1  write request valid
req_bit  input  1  value to store (1 = set, 0 = reset); sampled on handshake
req_ready  output  1  high only in IDLE
s  output  1  set excitation to the SR element
r  output  1  reset excitation to the SR element
q_fb  input  1  SR element q; asynchronous to clk
qbar_fb  input  1  SR element qbar; asynchronous to clk
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse on successful write
err  output  1  one-cycle pulse on failed write
err_code  output  2  valid with err: 01 = timeout, 10 = illegal feedback (q==qbar); holds last value until next err
stored  output  1  last value confirmed written

Behaviour:
- Reset (rst_n=0, asynchronous): s=0, r=0, busy=0, done=0, err=0, err_code=00, stored=0, req_ready=1, state=IDLE, counter=0, synchronizers cleared. All outputs are registered.
- Feedback path: q_fb and qbar_fb each pass through a 2-flop synchronizer. All decisions use only the synchronized values (qs, qbs).
- Handshake: transfer occurs when req_valid && req_ready on a rising edge. req_bit is latched into tgt. req_ready drops on the next cycle and returns high when the FSM re-enters IDLE. req_valid while busy is ignored; no queueing.
- State IDLE: on transfer, go to CHECK.
- State CHECK (1 cycle):
  - Skip path (see optional feature): go to DONE.
  - Otherwise load counter=PULSE_CYCLES and go to PULSE.
- State PULSE: s=tgt, r=~tgt. The counter decrements each cycle; at 1, go to SETTLE with counter=SETTLE_MAX. s/r are high for exactly PULSE_CYCLES cycles. s and r return to 0 on SETTLE entry.
- State SETTLE: s=r=0. Each cycle:
  - if qs==tgt && qbs==~tgt, go to DONE;
  - else if counter reaches 0, go to ERR: code 10 if qs==qbs on the final sample, else 01;
  - else decrement.
- State DONE (1 cycle): done=1, stored=tgt, then IDLE.
- State ERR (1 cycle): err=1, err_code set, stored unchanged, then IDLE.
- Latency (defaults, non-skip path, element settles in k sync'd cycles): handshake at cycle 0, CHECK at 1, PULSE at 2-3, SETTLE from 4, done at 5+k.
- Invariant: s&r==0 in every cycle, including reset, and both are 0 outside PULSE.
- Reset mid-operation: s/r drop within the same asynchronous reset event. An in-flight request is abandoned with no done/err.
- Simultaneous done-state exit and new req_valid: not accepted until req_ready=1 in IDLE, giving a minimum one-cycle gap between transfers.

Optional Feature:
SR_LATCH_DRV_SKIP_EN
- Defined: in CHECK, if qs==tgt && qbs==~tgt, skip PULSE/SETTLE and go straight to DONE. No s/r activity; done two cycles after handshake.
- Undefined: CHECK always proceeds to PULSE. Every write produces exactly PULSE_CYCLES cycles of s or r.

Test Plan:
- Reset then write 1; model settles 2 cycles after s rises -> s high cycles 2-3, r=0 throughout, done at cycle 6 or later, stored=1, busy low after.
- Write 0 after 1 -> r high exactly 2 cycles, s=0, done pulse, stored=0; assert s&r==0 every cycle.
- Model stuck (q_fb=0, qbar_fb=1) on write 1 -> after 8 SETTLE cycles err=1, err_code=01, stored unchanged, req_ready=1 next cycle.
- Model drives q_fb=qbar_fb=1 on write 0 -> err=1, err_code=10.
- Write 1 twice with SR_LATCH_DRV_SKIP_EN defined -> second write has no s pulse, done two cycles after handshake. Without the macro, the second write pulses s for 2 cycles.
- rst_n low during PULSE -> s=r=0 immediately, no done/err. After release: req_ready=1, stored=0.
